// File: rtl/div_iter_pkg.sv
// Shared constants and types for the iterative divider.
// The ALU sizes its wait logic from DIV_LATENCY.
package div_iter_pkg;

    localparam int unsigned DIV_ITERS   = 32;
    localparam int unsigned DIV_LATENCY = 34;
    localparam int unsigned CNT_W       = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPrep = 2'd1,
        StCalc = 2'd2,
        StFix  = 2'd3
    } div_state_e;

    // Magnitude of a 32-bit operand; only negated when treated as signed.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle.
// Division by zero and signed overflow short-circuit straight to FIX.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic            is_signed,
    input  logic [XLEN-1:0] s,
    input  logic [XLEN-1:0] t,
    output logic            completed,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r,
    output logic            busy
);

    localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

    div_state_e state_q, state_d;

    // acc holds {partial remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   div_q, div_d;
    logic              sgn_q, sgn_d;
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   q_q, q_d;
    logic [XLEN-1:0]   r_q, r_d;
    logic              done_q, done_d;

    // Trial subtraction includes the bit shifted out of the remainder.
    logic [XLEN:0]     trial_hi;
    logic [XLEN+1:0]   trial_diff;
    logic              trial_ok;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        trial_hi   = acc_q[2*XLEN-1:XLEN-1];
        trial_diff = {1'b0, trial_hi} - {2'b00, div_q};
        trial_ok   = ~trial_diff[XLEN+1];
        if (trial_ok) begin
            acc_step = {trial_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {acc_q[2*XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        div_d   = div_q;
        sgn_d   = sgn_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    div_d   = t;
                    sgn_d   = is_signed;
                    neg_q_d = 1'b0;
                    neg_r_d = 1'b0;
                    if (t == '0) begin
                        acc_d   = {s, {XLEN{1'b1}}};
                        state_d = StFix;
                    end else if (is_signed && (s == SMIN) && (t == {XLEN{1'b1}})) begin
                        acc_d   = {{XLEN{1'b0}}, SMIN};
                        state_d = StFix;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, s};
                        state_d = StPrep;
                    end
                end
            end

            StPrep: begin
                acc_d   = {{XLEN{1'b0}}, abs32(acc_q[XLEN-1:0], sgn_q)};
                div_d   = abs32(div_q, sgn_q);
                neg_q_d = sgn_q & (acc_q[XLEN-1] ^ div_q[XLEN-1]);
                neg_r_d = sgn_q & acc_q[XLEN-1];
                cnt_d   = CNT_LAST;
                state_d = StCalc;
            end

            StCalc: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end

            StFix: begin
                q_d     = neg_q_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
                r_d     = neg_r_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            acc_q   <= '0;
            div_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            sgn_q   <= sgn_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    assign completed = done_q;
    assign q         = q_q;
    assign r         = r_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus randomized
// operations against an arithmetic reference model.
module tb_div_iter;
    import div_iter_pkg::*;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        is_signed;
    logic [31:0] s;
    logic [31:0] t;
    logic        completed;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    div_iter #(.XLEN(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .is_signed (is_signed),
        .s         (s),
        .t         (t),
        .completed (completed),
        .q         (q),
        .r         (r),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M-extension division semantics in plain arithmetic.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         output logic [31:0] eq, output logic [31:0] er, output int lat);
        if (b == 32'd0) begin
            eq  = 32'hFFFF_FFFF;
            er  = a;
            lat = 1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            eq  = 32'h8000_0000;
            er  = 32'd0;
            lat = 1;
        end else if (sg) begin
            eq  = $signed(a) / $signed(b);
            er  = $signed(a) % $signed(b);
            lat = DIV_LATENCY;
        end else begin
            eq  = a / b;
            er  = a % b;
            lat = DIV_LATENCY;
        end
    endtask

    // Called #1 after a rising edge (or before the first); returns #1 after
    // the edge at which completed rose, so back-to-back calls start in that cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sg);
        logic [31:0] eq, er;
        int          lat;
        int          cyc;
        bit          seen;
        model(a, b, sg, eq, er, lat);
        s         = a;
        t         = b;
        is_signed = sg;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        enable    = 1'b0;
        s         = $urandom;
        t         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_no_double_pulse"}, 32'(completed), 32'd0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (completed) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_idle_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic watch(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (completed) hits++;
        end
    endtask

    initial begin
        int          hits;
        int          cyc;
        bit          seen;
        int          k;
        logic [31:0] ra, rb;

        rstn      = 1'b0;
        enable    = 1'b0;
        is_signed = 1'b0;
        s         = 32'd0;
        t         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_completed", 32'(completed), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        run_op("u100_7", 32'd100, 32'd7, 1'b0);
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op("u_div0", 32'h1234_5678, 32'd0, 1'b0);
        run_op("s_div0", 32'h1234_5678, 32'd0, 1'b1);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("u_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Enable while busy must be ignored.
        @(posedge clk);
        #1;
        s         = 32'd1000;
        t         = 32'd3;
        is_signed = 1'b0;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        s      = 32'd50;
        t      = 32'd5;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        cyc    = 6;
        seen   = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (completed) seen = 1'b1;
        end
        check("busy_en_latency", 32'(cyc), 32'(DIV_LATENCY));
        check("busy_en_q", q, 32'd333);
        check("busy_en_r", r, 32'd1);
        watch(40, hits);
        check("busy_en_single_pulse", 32'(hits), 32'd0);

        // Reset mid-operation aborts without a pulse.
        s         = 32'd12345;
        t         = 32'd67;
        is_signed = 1'b0;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        watch(10, hits);
        check("rst_mid_no_early", 32'(hits), 32'd0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_completed", 32'(completed), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_q", q, 32'd0);
        check("rst_mid_r", r, 32'd0);
        rstn = 1'b1;
        watch(40, hits);
        check("rst_mid_no_pulse", 32'(hits), 32'd0);
        run_op("post_rst", 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Randomized operations issued back-to-back on each completed pulse.
        for (int i = 0; i < 40; i++) begin
            k  = int'($urandom_range(0, 9));
            ra = $urandom;
            rb = $urandom;
            case (k)
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'd1;
                3: ra = 32'h8000_0000;
                4: rb = 32'($urandom_range(1, 15));
                5: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                6: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port enable, input, 1 bit: start request, sampled only in IDLE.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 = DIV/REM semantics, 0 = DIVU/REMU.
REQ-006 The block SHALL have port s, input, 32 bits: dividend, captured with enable.
REQ-007 The block SHALL have port t, input, 32 bits: divisor, captured with enable.
REQ-008 The block SHALL have port completed, output, 1 bit: one-cycle pulse, q/r valid.
REQ-009 The block SHALL have port q, output, 32 bits: quotient.
REQ-010 The block SHALL have port r, output, 32 bits: remainder.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-012 States SHALL be IDLE, PREP, CALC and FIX, encoded as a 2-bit enum.
REQ-013 IDLE with enable=1 SHALL latch s, t and is_signed, then go to PREP; the normal-path start edge is edge N.
REQ-014 PREP SHALL take absolute values when is_signed=1 (the sign bit selects negation), record neg_q = s[31]^t[31] and neg_r = s[31], clear the 64-bit partial remainder, and load the iteration counter with 31.
REQ-015 CALC SHALL perform one restoring radix-2 step per cycle for 32 cycles: shift, trial subtract, set quotient bit when no borrow; the counter decrements and wraps out to FIX at 0.
REQ-016 FIX SHALL negate q when neg_q, negate r when neg_r, drive completed=1 for one cycle, and return to IDLE.
REQ-017 Normal latency SHALL be fixed: completed high in the cycle after edge N+34 (DIV_LATENCY=34) for every operand pair.
REQ-018 When t=0 in IDLE, the block SHALL give q=32'hFFFFFFFF and r=s with completed at edge N+1, for both signednesses, without entering PREP.
REQ-019 When is_signed=1, s=32'h80000000 and t=32'hFFFFFFFF, the block SHALL give q=32'h80000000 and r=0 with completed at edge N+1.
REQ-020 enable while busy=1 SHALL be ignored; the in-flight operation is not disturbed and no second result is queued.
REQ-021 enable in the same cycle completed is high SHALL be accepted, since the block is IDLE that cycle, and SHALL start a new operation at that edge.
REQ-022 q and r SHALL hold their last values until the next completed pulse; input changes after capture SHALL have no effect.
REQ-023 completed SHALL never be high for two consecutive cycles.

Reset
REQ-024 With rstn=0 at a clock edge, the block SHALL enter IDLE with completed=0, busy=0, q=0, r=0 and all internal registers cleared.
REQ-025 Reset mid-operation SHALL abort the operation without any completed pulse; the first enable after rstn returns high SHALL start cleanly.

Structure
REQ-026 The state enum and the constants DIV_LATENCY=34 and DIV_ITERS=32 SHALL live in the shared core package so the ALU can size its wait logic.
REQ-027 No sub-module is warranted; the datapath SHALL be a single module with one subtractor and one 64-bit shift register.

Verification
REQ-028 Bench SHALL cover: unsigned s=100, t=7 -> q=14, r=2, completed exactly 34 cycles after enable.
REQ-029 Bench SHALL cover: signed s=-7 (32'hFFFFFFF9), t=2 -> q=32'hFFFFFFFD, r=32'hFFFFFFFF; signed s=7, t=-2 -> q=-3, r=1.
REQ-030 Bench SHALL cover: t=0 with s=32'h12345678, both signednesses -> q=32'hFFFFFFFF, r=32'h12345678, completed 1 cycle after enable.
REQ-031 Bench SHALL cover: signed 32'h80000000 / 32'hFFFFFFFF -> q=32'h80000000, r=0 in 1 cycle; unsigned, same operands -> q=0, r=32'h80000000 in 34 cycles.
REQ-032 Bench SHALL cover: enable pulsed again 5 cycles into an operation with other operands -> ignored, single completed with the first result.
REQ-033 Bench SHALL cover: rstn low 10 cycles into an operation -> no completed pulse, outputs 0; next unsigned 32'hFFFFFFFF / 1 -> q=32'hFFFFFFFF, r=0.
